// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: the counter is the slave,
// whoever steps it (a sequencer, a testbench) is the master.
`timescale 1ns/1ps
interface mod_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tc, wrap, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tc, wrap, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter over 0..MAX_VAL with load, clear, enable and a
// wrap-or-saturate boundary policy; reports terminal count, wrap pulse, sticky overflow.
`timescale 1ns/1ps
module mod_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = 0
) (
  input  logic          clk,
  input  logic          rst,
  mod_counter_if.slave  bus
);

  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             ovf_reg;
  logic             ovf_next;

  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] up_value;
  logic [WIDTH-1:0] down_value;

  assign at_max   = (count_reg == MAX_VAL);
  assign at_zero  = (count_reg == '0);
  assign boundary = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));

  // Out-of-range loads are clamped so the count can never hold an illegal value.
  assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

  // Boundaries are tested before the +/-1 so no WIDTH-bit overflow leaks out
  // when MAX_VAL is below the full binary range.
  assign up_value   = at_max  ? (SAT ? MAX_VAL : '0) : count_reg + WIDTH'(1);
  assign down_value = at_zero ? (SAT ? '0 : MAX_VAL) : count_reg - WIDTH'(1);

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    ovf_next   = ovf_reg;
    if (bus.clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (bus.load) begin
      count_next = load_clamped;
    end else if (bus.en) begin
      count_next = bus.up ? up_value : down_value;
      if (boundary) begin
        wrap_next = 1'b1;
        ovf_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.count = count_reg;
  assign bus.wrap  = wrap_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.tc    = boundary;

`ifdef FORMAL
  logic             past_valid_reg;
  logic             prev_en_reg;
  logic             prev_up_reg;
  logic             prev_clr_reg;
  logic             prev_load_reg;
  logic [WIDTH-1:0] prev_count_reg;

  // Previous-cycle context captured by hand so every check is reset-aware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      past_valid_reg <= 1'b0;
      prev_en_reg    <= 1'b0;
      prev_up_reg    <= 1'b0;
      prev_clr_reg   <= 1'b0;
      prev_load_reg  <= 1'b0;
      prev_count_reg <= '0;
    end else begin
      past_valid_reg <= 1'b1;
      prev_en_reg    <= bus.en;
      prev_up_reg    <= bus.up;
      prev_clr_reg   <= bus.clr;
      prev_load_reg  <= bus.load;
      prev_count_reg <= count_reg;
    end
  end

  always_comb begin
    if (rst) begin
      a_range : assert (count_reg <= MAX_VAL);
      a_wrap_ovf : assert (!wrap_reg || ovf_reg);
    end
    if (rst && past_valid_reg) begin
      if (prev_clr_reg) begin
        a_clr : assert (count_reg == '0 && !ovf_reg);
      end
      if (prev_en_reg && !prev_clr_reg && !prev_load_reg && prev_up_reg) begin
        a_up : assert (count_reg == ((prev_count_reg == MAX_VAL)
                                     ? (SAT ? MAX_VAL : '0)
                                     : prev_count_reg + WIDTH'(1)));
      end
      if (prev_en_reg && !prev_clr_reg && !prev_load_reg && !prev_up_reg) begin
        a_down : assert (count_reg == ((prev_count_reg == '0)
                                       ? (SAT ? '0 : MAX_VAL)
                                       : prev_count_reg - WIDTH'(1)));
      end
    end
  end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboarded bench: two counters (wrap and saturate, WIDTH=4, MAX_VAL=9) share
// one stimulus stream; a modulo-arithmetic model predicts each, a monitor compares.
`timescale 1ns/1ps
module tb_mod_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  typedef struct {
    int count;
    int wrap;
    int ovf;
    int tc;
  } exp_t;

  logic clk;
  logic rst;

  mod_counter_if #(.WIDTH(W)) bus0 ();
  mod_counter_if #(.WIDTH(W)) bus1 ();

  mod_counter #(.WIDTH(W), .MAX_VAL(4'd9), .SATURATE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mod_counter #(.WIDTH(W), .MAX_VAL(4'd9), .SATURATE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q0[$];
  exp_t q1[$];

  int   m_count[2];
  int   m_wrap[2];
  int   m_ovf[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_count[s] = 0;
      m_wrap[s]  = 0;
      m_ovf[s]   = 0;
    end
  endfunction

  // Reference: take the unbounded +/-1 step, then fold it back into 0..MAXV
  // by modulo (wrap mode) or clamping (saturate mode).
  function automatic exp_t model_cycle(input int s, input bit en, input bit up,
                                       input bit clr, input bit load, input int lv);
    exp_t e;
    int   nxt;
    if (clr) begin
      m_count[s] = 0;
      m_wrap[s]  = 0;
      m_ovf[s]   = 0;
    end else if (load) begin
      m_count[s] = (lv > MAXV) ? MAXV : lv;
      m_wrap[s]  = 0;
    end else if (en) begin
      nxt        = m_count[s] + (up ? 1 : -1);
      m_wrap[s]  = (nxt < 0 || nxt > MAXV) ? 1 : 0;
      if (m_wrap[s] != 0) m_ovf[s] = 1;
      if (s == 1) m_count[s] = (nxt < 0) ? 0 : ((nxt > MAXV) ? MAXV : nxt);
      else        m_count[s] = (nxt + MAXV + 1) % (MAXV + 1);
    end else begin
      m_wrap[s] = 0;
    end
    e.count = m_count[s];
    e.wrap  = m_wrap[s];
    e.ovf   = m_ovf[s];
    e.tc    = (en && ((up && m_count[s] == MAXV) || (!up && m_count[s] == 0))) ? 1 : 0;
    return e;
  endfunction

  // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
  task automatic cyc(input bit en, input bit up, input bit clr, input bit load, input int lv);
    bus0.en = en;  bus0.up = up;  bus0.clr = clr;  bus0.load = load;  bus0.load_val = W'(lv);
    bus1.en = en;  bus1.up = up;  bus1.clr = clr;  bus1.load = load;  bus1.load_val = W'(lv);
    q0.push_back(model_cycle(0, en, up, clr, load, lv));
    q1.push_back(model_cycle(1, en, up, clr, load, lv));
    @(negedge clk);
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock edge.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_async_count0", int'(bus0.count), 0);
    check("rst_async_wrap0",  int'(bus0.wrap),  0);
    check("rst_async_ovf0",   int'(bus0.ovf),   0);
    check("rst_async_count1", int'(bus1.count), 0);
    check("rst_async_ovf1",   int'(bus1.ovf),   0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_count0", int'(bus0.count), 0);
    check("rst_hold_count1", int'(bus1.count), 0);
    @(negedge clk);
    rst = 1'b1;
    $display("reset pulse applied at %0t", $time);
  endtask

  task automatic compare(input int s, input exp_t e, input int c, input int w,
                         input int o, input int t);
    $display("dut%0d count=%0d wrap=%0d ovf=%0d tc=%0d (model %0d %0d %0d %0d)",
             s, c, w, o, t, e.count, e.wrap, e.ovf, e.tc);
    check($sformatf("count_dut%0d", s), c, e.count);
    check($sformatf("wrap_dut%0d", s),  w, e.wrap);
    check($sformatf("ovf_dut%0d", s),   o, e.ovf);
    check($sformatf("tc_dut%0d", s),    t, e.tc);
  endtask

  // Monitor: after each rising edge, every pending prediction is retired.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, int'(bus0.count), int'(bus0.wrap), int'(bus0.ovf), int'(bus0.tc));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, int'(bus1.count), int'(bus1.wrap), int'(bus1.ovf), int'(bus1.tc));
      end
    end
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL timeout actual=running required=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int r;
    rst = 1'b0;
    bus0.en = 0; bus0.up = 0; bus0.clr = 0; bus0.load = 0; bus0.load_val = '0;
    bus1.en = 0; bus1.up = 0; bus1.clr = 0; bus1.load = 0; bus1.load_val = '0;
    model_reset();
    #2;
    check("reset_count0", int'(bus0.count), 0);
    check("reset_wrap0",  int'(bus0.wrap),  0);
    check("reset_ovf0",   int'(bus0.ovf),   0);
    check("reset_tc0",    int'(bus0.tc),    0);
    check("reset_count1", int'(bus1.count), 0);
    @(negedge clk);
    rst = 1'b1;

    // Free count up through the wrap point.
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0);
    // Out-of-range load clamps, then one step crosses the boundary.
    cyc(0, 1, 0, 1, 13);
    cyc(1, 1, 0, 0, 0);
    // Down from 2 into the lower boundary.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    // Priority: clr over load over en.
    cyc(0, 1, 0, 1, 7);
    cyc(1, 1, 1, 1, 5);
    cyc(1, 1, 0, 1, 5);
    // Direction flips at the top.
    cyc(0, 1, 0, 1, 9);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    // Asynchronous reset mid-count at 6, then resume counting.
    cyc(0, 1, 0, 1, 2);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
    async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)));
      end
    end

    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised up/down modulo counter. It is the next generation of the fixed 4-bit free-running counter.
- Adds configurable width and terminal value, direction control, synchronous load and clear, count enable, and a wrap or saturate mode.
- Provides terminal-count, wrap-event and sticky-overflow status.
- Used as a timer/sequence-index primitive across datapath and control blocks; intended for formal sign-off with embedded properties under FORMAL.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1: terminal (highest) count value; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1. The count range is 0..MAX_VAL.
- SATURATE, 0: 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronised upstream.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled each cycle.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  load value.
- count  output  WIDTH  registered count.
- tc  output  1  combinational terminal-count: en & ((up & count==MAX_VAL) | (~up & count==0)).
- wrap  output  1  registered 1-cycle pulse: a boundary step occurred last cycle (wrapped or saturated).
- ovf  output  1  sticky flag: at least one boundary step since the last clr/reset.

Behaviour:
- Reset (rst=0, async): count=0, wrap=0, ovf=0 immediately, with no clock needed. All outputs hold at these values while rst=0.
- Priority per rising edge (rst=1): clr > load > en > hold.
- clr=1: count<=0, ovf<=0, wrap<=0. This overrides load and en in the same cycle.
- load=1 (clr=0): count<=min(load_val, MAX_VAL); wrap<=0; ovf unchanged. An out-of-range load_val is clamped, never stored raw.
- en=1, up=1, count<MAX_VAL: count<=count+1, wrap<=0.
- en=1, up=1, count==MAX_VAL:
  - SATURATE=0: count<=0.
  - SATURATE=1: count holds MAX_VAL.
  - Both modes: wrap<=1, ovf<=1.
- en=1, up=0, count>0: count<=count-1, wrap<=0.
- en=1, up=0, count==0:
  - SATURATE=0: count<=MAX_VAL.
  - SATURATE=1: count holds 0.
  - Both modes: wrap<=1, ovf<=1.
- en=0 (no clr/load): count holds; wrap<=0.
- Arithmetic is WIDTH bits. The count never leaves 0..MAX_VAL, including when MAX_VAL < 2**WIDTH-1 (no intermediate WIDTH overflow is ever visible).
- Direction may change on any cycle without a penalty cycle. A step after a direction change is a normal step.
- Latency: count reflects a control input 1 cycle after the sampling edge. tc has zero latency. wrap is asserted the cycle after the boundary step, concurrently with the new count.
- Reset mid-operation: counting restarts from 0 after rst returns high; no state is retained.
- Formal properties (FORMAL only), with a past-valid guard gated by rst:
  - count <= MAX_VAL always.
  - With en, no clr/load and up=1 on the previous cycle: count == (prev==MAX_VAL ? (SATURATE ? MAX_VAL : 0) : prev+1).
  - The mirror of the above for up=0.
  - wrap implies ovf.
  - After clr: count==0 and ovf==0.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0, up=1, en=1 for 12 cycles from reset → count 0..9,0,1. tc high while count==9; wrap=1 exactly in the cycle count becomes 0; ovf=1 from then on.
- Same config, load=1 with load_val=13 → count=9 next cycle. Then one up step → count=0, wrap=1.
- SATURATE=1, up=0, from count=2, en=1 for 4 cycles → count 1,0,0,0. wrap=1 on each of the last two; ovf=1.
- Simultaneous clr=1, load=1 (load_val=5), en=1 at count=7 → count=0, ovf=0, wrap=0. Then load=1 with en=1 → count=5 (load beats en).
- Direction flip: count=9 (MAX_VAL=9), up toggles 1,0,1 with en=1 → count 0,9,0. wrap pulses on each cycle.
- Assert rst=0 asynchronously mid-count at count=6, between clock edges → count=0, wrap=0, ovf=0 before the next edge. Releasing reset with en=1 → count 1,2,...
